// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit family: operation encodings and
// the parity/zero flag helper also used by the arithmetic unit.
package logic_unit_pkg;

    localparam int OP_W = 3;

    // Widest result the shared flag helper handles; narrower results are zero-extended.
    localparam int FLAG_MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NOR    = 3'b011,
        OP_NAND   = 3'b100,
        OP_XNOR   = 3'b101,
        OP_ANDN   = 3'b110,
        OP_PASS_B = 3'b111
    } op_e;

    // Returns {odd parity, zero}. Zero-extension leaves both flags unchanged.
    function automatic logic [1:0] parity_zero(input logic [FLAG_MAX_W-1:0] value);
        return {^value, (value == '0)};
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational W-bit bitwise operation mux with N/Z/P flag generation.
// W must lie between 2 and FLAG_MAX_W.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    op_a,
    input  logic [W-1:0]    op_b,
    output logic [W-1:0]    res,
    output logic            n,
    output logic            z,
    output logic            p
);

    always_comb begin
        res = '0;
        case (op_e'(op))
            OP_AND:    res = op_a & op_b;
            OP_OR:     res = op_a | op_b;
            OP_XOR:    res = op_a ^ op_b;
            OP_NOR:    res = ~(op_a | op_b);
            OP_NAND:   res = ~(op_a & op_b);
            OP_XNOR:   res = ~(op_a ^ op_b);
            OP_ANDN:   res = op_a & ~op_b;
            OP_PASS_B: res = op_b;
            default:   res = '0;
        endcase
    end

    assign n      = res[W-1];
    assign {p, z} = parity_zero(FLAG_MAX_W'(res));

endmodule

// File: rtl/logic_unit_pipe.sv
// Single-entry registered logic unit: valid/ready handshake, accumulator
// that can stand in for operand A, and a saturating accepted-op counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     data_a,
    input  logic [W-1:0]     data_b,
    input  logic [OP_W-1:0]  op,
    input  logic             use_acc,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic [CNT_W-1:0] op_count
);

    logic [W-1:0] acc;
    logic [W-1:0] op_a;
    logic [W-1:0] res;
    logic         res_n;
    logic         res_z;
    logic         res_p;
    logic         accept;
    logic         transfer;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;

    // A clear requested alongside use_acc must already see zero this cycle.
    assign op_a = use_acc ? (clr_acc ? '0 : acc) : data_a;

    logic_unit_core #(.W(W)) u_core (
        .op   (op),
        .op_a (op_a),
        .op_b (data_b),
        .res  (res),
        .n    (res_n),
        .z    (res_z),
        .p    (res_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            n         <= 1'b0;
            z         <= 1'b0;
            p         <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= res;
            n         <= res_n;
            z         <= res_z;
            p         <= res_p;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    // While stalled all inputs are ignored, so a bare clear only lands when ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= res;
        end else if (clr_acc && in_ready) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed ops push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_logic_unit_pipe;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] T_AND    = 3'b000;
    localparam logic [2:0] T_OR     = 3'b001;
    localparam logic [2:0] T_XOR    = 3'b010;
    localparam logic [2:0] T_NOR    = 3'b011;
    localparam logic [2:0] T_NAND   = 3'b100;
    localparam logic [2:0] T_XNOR   = 3'b101;
    localparam logic [2:0] T_ANDN   = 3'b110;
    localparam logic [2:0] T_PASS_B = 3'b111;

    typedef struct packed {
        logic [7:0] data;
        logic       n;
        logic       z;
        logic       p;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     data_a;
    logic [W-1:0]     data_b;
    logic [2:0]       op;
    logic             use_acc;
    logic             clr_acc;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             n;
    logic             z;
    logic             p;
    logic [CNT_W-1:0] op_count;

    exp_t exp_q[$];
    exp_t mon_e;
    int   num_checks = 0;
    int   num_fails  = 0;

    logic_unit_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .op        (op),
        .use_acc   (use_acc),
        .clr_acc   (clr_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .n         (n),
        .z         (z),
        .p         (p),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Holds the operands until the DUT takes them, then queues the expected result.
    task automatic applyStimulus(input logic [2:0] op_i, input logic [7:0] a, input logic [7:0] b,
                                 input logic ua, input logic ca,
                                 input logic [7:0] ed, input logic en, input logic ez, input logic ep);
        int   cycles   = 0;
        bit   accepted = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        op       = op_i;
        data_a   = a;
        data_b   = b;
        use_acc  = ua;
        clr_acc  = ca;
        while (!accepted && cycles < 50) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else cycles++;
        end
        if (!accepted) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
        end else begin
            e.data = ed;
            e.n    = en;
            e.z    = ez;
            e.p    = ep;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        use_acc  = 1'b0;
        clr_acc  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                num_checks++;
                num_fails++;
                $display("[TB] FAIL unexpected_result: got data 0x%0h with nothing queued, expected no transfer", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("result{data,n,z,p}", {21'b0, out_data, n, z, p},
                            {21'b0, mon_e.data, mon_e.n, mon_e.z, mon_e.p});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drain;
        logic [7:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        data_a    = '0;
        data_b    = '0;
        use_acc   = 1'b0;
        clr_acc   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 0);
        checkOutput("reset_out_data", {24'b0, out_data}, 0);
        checkOutput("reset_flags", {29'b0, n, z, p}, 0);
        checkOutput("reset_op_count", {28'b0, op_count}, 0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 1);
        rst_n = 1'b1;

        $display("[TB] reset mid-stream");
        applyStimulus(T_AND, 8'h0F, 8'h33, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("pending_valid", {31'b0, out_valid}, 1);
        checkOutput("pending_count", {28'b0, op_count}, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, out_valid}, 0);
        checkOutput("async_rst_data", {24'b0, out_data}, 0);
        checkOutput("async_rst_count", {28'b0, op_count}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("post_rst_in_ready", {31'b0, in_ready}, 1);

        $display("[TB] basic ops");
        out_ready = 1'b1;
        applyStimulus(T_AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        applyStimulus(T_XOR, 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("count_after_2", {28'b0, op_count}, 2);
        checkOutput("drained_valid", {31'b0, out_valid}, 0);
        applyStimulus(T_NOR, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(T_ANDN, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("count_after_4", {28'b0, op_count}, 4);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(T_AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        op       = T_OR;
        data_a   = 8'h0F;
        data_b   = 8'h01;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_in_ready", {31'b0, in_ready}, 0);
            checkOutput("stall_out_data", {24'b0, out_data}, 32'h30);
            checkOutput("stall_count", {28'b0, op_count}, 5);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(T_OR, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        checkOutput("same_cycle_valid", {31'b0, out_valid}, 1);
        checkOutput("same_cycle_data", {24'b0, out_data}, 32'h0F);
        checkOutput("same_cycle_count", {28'b0, op_count}, 6);
        idle();

        $display("[TB] accumulator");
        applyStimulus(T_OR, 8'h5A, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        applyStimulus(T_OR, 8'h5A, 8'h80, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0);
        applyStimulus(T_XNOR, 8'h00, 8'h81, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(T_AND, 8'h3C, 8'hFF, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(T_AND, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(T_NAND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'hCF, 1'b1, 1'b0, 1'b0);
        applyStimulus(T_PASS_B, 8'hFF, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1);
        idle();

        $display("[TB] counter saturation");
        for (int i = 0; i < 17; i++) begin
            v = 8'h10 + 8'(i);
            applyStimulus(T_PASS_B, 8'h00, v, 1'b0, 1'b0, v, 1'b0, 1'b0, ^v);
        end
        idle();
        @(posedge clk);
        #1;
        checkOutput("count_saturated", {28'b0, op_count}, 32'hF);
        clr_acc = 1'b1;
        @(posedge clk);
        #1 clr_acc = 1'b0;
        checkOutput("count_after_clr", {28'b0, op_count}, 32'hF);
        applyStimulus(T_OR, 8'hAA, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle();
        checkOutput("count_still_sat", {28'b0, op_count}, 32'hF);

        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
